// File: rtl/pixel_readout_pkg.sv
// Shared types and sizing helpers for the pixel readout sequencer.
package pixel_readout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        PRESENT
    } state_t;

    function automatic int calc_num_groups(input int width, input int height, input int obpw);
        return (width * height) / obpw;
    endfunction

    // A single group still needs a one-bit index register.
    function automatic int calc_group_width(input int num_groups);
        return (num_groups > 1) ? $clog2(num_groups) : 1;
    endfunction

endpackage

// File: rtl/readout_group_counter.sv
// Group index register with clear/increment, last-group flag and gated one-hot select decode.
module readout_group_counter
    import pixel_readout_pkg::*;
#(
    parameter int NUM_GROUPS = 2
) (
    input  logic                  SYSTEM_CLK,
    input  logic                  SYSTEM_RESET,
    input  logic                  clear,
    input  logic                  incr,
    input  logic                  select_en,
    output logic                  last_group,
    output logic [NUM_GROUPS-1:0] read_select
);

    localparam int GW = calc_group_width(NUM_GROUPS);

    logic [GW-1:0] group_idx;

    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET || clear) begin
            group_idx <= '0;
        end else if (incr) begin
            group_idx <= group_idx + 1'b1;
        end
    end

    assign last_group = (group_idx == GW'(NUM_GROUPS - 1));

    // Compare against each legal index so unused index codes never decode.
    always_comb begin
        read_select = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            read_select[g] = select_en && (group_idx == GW'(g));
        end
    end

endmodule

// File: rtl/pixel_readout_sequencer.sv
// Steps through pixel groups, captures each off the shared bus and hands it out over valid/ready.
// Optional frame flags (out_sof/out_eof) are enabled by defining READOUT_FRAME_FLAGS_EN.
module pixel_readout_sequencer
    import pixel_readout_pkg::*;
#(
    parameter int WIDTH                  = 2,
    parameter int HEIGHT                 = 2,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int BIT_DEPTH              = 8,
    parameter int SETTLE_CYCLES          = 1,
    localparam int NUM_GROUPS = calc_num_groups(WIDTH, HEIGHT, OUTPUT_BUS_PIXEL_WIDTH),
    localparam int DW         = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH
) (
    input  logic                  SYSTEM_CLK,
    input  logic                  SYSTEM_RESET,
    input  logic                  read_start,
    input  logic [DW-1:0]         pixel_data,
    output logic [NUM_GROUPS-1:0] read_select,
    output logic [DW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  busy,
    output logic                  read_done
);

    localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

    state_t        state, next_state;
    logic [SW-1:0] settle_cnt;
    logic          grp_clear, grp_incr, load_settle, dec_settle, capture, done_set;
    logic          last_group;

    readout_group_counter #(
        .NUM_GROUPS (NUM_GROUPS)
    ) u_group_counter (
        .SYSTEM_CLK   (SYSTEM_CLK),
        .SYSTEM_RESET (SYSTEM_RESET),
        .clear        (grp_clear),
        .incr         (grp_incr),
        .select_en    (state == SELECT),
        .last_group   (last_group),
        .read_select  (read_select)
    );

    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        grp_clear   = 1'b0;
        grp_incr    = 1'b0;
        load_settle = 1'b0;
        dec_settle  = 1'b0;
        capture     = 1'b0;
        done_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (read_start) begin
                    next_state  = SELECT;
                    grp_clear   = 1'b1;
                    load_settle = 1'b1;
                end
            end
            SELECT: begin
                if (settle_cnt != '0) begin
                    dec_settle = 1'b1;
                end else begin
                    capture    = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (last_group) begin
                        next_state = IDLE;
                        grp_clear  = 1'b1;
                        done_set   = 1'b1;
                    end else begin
                        next_state  = SELECT;
                        grp_incr    = 1'b1;
                        load_settle = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) begin
            settle_cnt <= '0;
            out_data   <= '0;
            read_done  <= 1'b0;
        end else begin
            read_done <= done_set;
            if (load_settle) begin
                settle_cnt <= SETTLE_LOAD;
            end else if (dec_settle) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (capture) begin
                out_data <= pixel_data;
            end
        end
    end

    assign out_valid = (state == PRESENT);
    assign busy      = (state != IDLE);

`ifdef READOUT_FRAME_FLAGS_EN
    // At capture the one-hot select still marks the group, so bit 0 identifies the first word.
    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) begin
            out_sof <= 1'b0;
            out_eof <= 1'b0;
        end else if (capture) begin
            out_sof <= read_select[0];
            out_eof <= last_group;
        end
    end
`else
    assign out_sof = 1'b0;
    assign out_eof = 1'b0;
`endif

endmodule
